// File: rtl/video_capture_pkg.sv
// Shared state type and helpers for the video_capture block and its sync front end.
package video_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEEK    = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } cap_state_e;

    // Width of the per-axis decimation down-counters (FB_SCALE is at most 63).
    localparam int MODW = 6;

    // Map a sync input to active-high whatever the source polarity.
    function automatic logic sync_norm(input logic sync_in, input logic active_high);
        return active_high ? sync_in : ~sync_in;
    endfunction

endpackage

// File: rtl/video_sync_edge.sv
// Input register stages for the incoming video: polarity-normalised vsync edge,
// de rise/fall strobes and the colour word aligned with them.
module video_sync_edge
    import video_capture_pkg::*;
#(
    parameter int CHANW    = 4,
    parameter int SYNC_POL = 0
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               vsync_i,
    input  logic               de_i,
    input  logic [3*CHANW-1:0] colr_i,
    output logic               vsync_edge_o,
    output logic               de_o,
    output logic               de_rise_o,
    output logic               de_fall_o,
    output logic [3*CHANW-1:0] colr_o
);

    localparam logic ACT_HIGH = (SYNC_POL != 0);

    logic               vs1_q;
    logic               vs2_q;
    logic               de1_q;
    logic               de2_q;
    logic [3*CHANW-1:0] colr1_q;

    // First stage captures the pins, second stage holds the previous sync/de for edge detection.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vs1_q   <= 1'b0;
            vs2_q   <= 1'b0;
            de1_q   <= 1'b0;
            de2_q   <= 1'b0;
            colr1_q <= '0;
        end else begin
            vs1_q   <= sync_norm(vsync_i, ACT_HIGH);
            vs2_q   <= vs1_q;
            de1_q   <= de_i;
            de2_q   <= de1_q;
            colr1_q <= colr_i;
        end
    end

    assign vsync_edge_o = vs1_q & ~vs2_q;
    assign de_o         = de1_q;
    assign de_rise_o    = de1_q & ~de2_q;
    assign de_fall_o    = ~de1_q & de2_q;
    assign colr_o       = colr1_q;

endmodule

// File: rtl/video_capture.sv
// Captures a decimated window of a DVI-style stream into the framebuffer write port.
// Optional VIDEO_CAPTURE_STATS_EN enables the measured width/height outputs.
module video_capture
    import video_capture_pkg::*;
#(
    parameter int CHANW     = 4,
    parameter int CORDW     = 16,
    parameter int FB_WIDTH  = 160,
    parameter int FB_HEIGHT = 90,
    parameter int FB_SCALE  = 4,
    parameter int CAP_OFFX  = 0,
    parameter int CAP_OFFY  = 60,
    parameter int SYNC_POL  = 0,
    parameter int ADDRW     = $clog2(FB_WIDTH*FB_HEIGHT)
) (
    input  logic               clk_pix,
    input  logic               rst_pix_n,
    input  logic               enable,
    input  logic               vid_hsync,
    input  logic               vid_vsync,
    input  logic               vid_de,
    input  logic [CHANW-1:0]   vid_r,
    input  logic [CHANW-1:0]   vid_g,
    input  logic [CHANW-1:0]   vid_b,
    output logic               fb_we,
    output logic [ADDRW-1:0]   fb_addr,
    output logic [3*CHANW-1:0] fb_colr,
    output logic               capturing,
    output logic               locked,
    output logic               frame_done,
    output logic               err_short,
    output logic [CORDW-1:0]   meas_w,
    output logic [CORDW-1:0]   meas_h
);

    localparam logic [MODW-1:0]  SC_M1 = MODW'(FB_SCALE - 1);
    localparam logic [CORDW-1:0] OFFX  = CORDW'(CAP_OFFX);
    localparam logic [CORDW-1:0] OFFY  = CORDW'(CAP_OFFY);
    localparam logic [CORDW-1:0] FBW   = CORDW'(FB_WIDTH);
    localparam logic [CORDW-1:0] FBH   = CORDW'(FB_HEIGHT);
    localparam logic [CORDW-1:0] CMAX  = '1;
    localparam logic [ADDRW-1:0] LAST  = ADDRW'(FB_WIDTH*FB_HEIGHT - 1);

    function automatic logic [CORDW-1:0] sat_inc(input logic [CORDW-1:0] v);
        return (v == CMAX) ? v : v + CORDW'(1);
    endfunction

    logic               vsync_edge_s, de_s, de_rise_s, de_fall_s;
    logic [3*CHANW-1:0] colr_s;
    logic               unused_s;

    // Lines are delimited by de, so hsync carries nothing this block needs.
    assign unused_s = vid_hsync;

    video_sync_edge #(.CHANW(CHANW), .SYNC_POL(SYNC_POL)) u_sync (
        .clk_i        (clk_pix),
        .rst_n_i      (rst_pix_n),
        .vsync_i      (vid_vsync),
        .de_i         (vid_de),
        .colr_i       ({vid_r, vid_g, vid_b}),
        .vsync_edge_o (vsync_edge_s),
        .de_o         (de_s),
        .de_rise_o    (de_rise_s),
        .de_fall_o    (de_fall_s),
        .colr_o       (colr_s)
    );

    logic [CORDW-1:0] ax_q, ax_d, ay_q, ay_d, fbx_q, fbx_d, fby_q, fby_d;
    logic [MODW-1:0]  mx_q, mx_d, my_q, my_d;
    logic             x_in_q, x_in_d, y_in_q, y_in_d;
    logic [CORDW-1:0] cur_x_s, cur_fbx_s;
    logic [MODW-1:0]  cur_mx_s;
    logic             x_hit_s, x_tick_s, y_hit_s, y_tick_s, sample_s;

    // Window/decimation tracking: x state restarts at de rise, y state at the vsync edge.
    always_comb begin
        cur_x_s   = de_rise_s ? '0 : ax_q;
        cur_fbx_s = de_rise_s ? '0 : fbx_q;
        cur_mx_s  = (de_rise_s || !x_in_q) ? '0 : mx_q;
        x_hit_s   = (x_in_q && !de_rise_s) || (cur_x_s == OFFX);
        x_tick_s  = x_hit_s && (cur_mx_s == '0);
        y_hit_s   = y_in_q || (ay_q == OFFY);
        y_tick_s  = y_hit_s && (my_q == '0);
        sample_s  = de_s && x_tick_s && (cur_fbx_s < FBW) && y_tick_s && (fby_q < FBH);

        if (de_s) begin
            ax_d   = sat_inc(cur_x_s);
            x_in_d = x_hit_s;
            mx_d   = !x_hit_s ? '0 : ((cur_mx_s == '0) ? SC_M1 : cur_mx_s - MODW'(1));
            fbx_d  = x_tick_s ? sat_inc(cur_fbx_s) : cur_fbx_s;
        end else begin
            ax_d   = ax_q;
            x_in_d = x_in_q;
            mx_d   = mx_q;
            fbx_d  = fbx_q;
        end

        if (vsync_edge_s) begin
            ay_d   = '0;
            y_in_d = 1'b0;
            my_d   = '0;
            fby_d  = '0;
        end else if (de_fall_s) begin
            ay_d   = sat_inc(ay_q);
            y_in_d = y_hit_s;
            my_d   = !y_hit_s ? '0 : ((my_q == '0) ? SC_M1 : my_q - MODW'(1));
            fby_d  = y_tick_s ? sat_inc(fby_q) : fby_q;
        end else begin
            ay_d   = ay_q;
            y_in_d = y_in_q;
            my_d   = my_q;
            fby_d  = fby_q;
        end
    end

    // Position and decimation counter registers.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            ax_q <= '0; ay_q <= '0; fbx_q <= '0; fby_q <= '0;
            mx_q <= '0; my_q <= '0; x_in_q <= 1'b0; y_in_q <= 1'b0;
        end else begin
            ax_q <= ax_d; ay_q <= ay_d; fbx_q <= fbx_d; fby_q <= fby_d;
            mx_q <= mx_d; my_q <= my_d; x_in_q <= x_in_d; y_in_q <= y_in_d;
        end
    end

    cap_state_e         state_q;
    logic [ADDRW-1:0]   wptr_q, fb_addr_q;
    logic [3*CHANW-1:0] fb_colr_q;
    logic               fb_we_q, locked_q, frame_done_q, err_short_q;

    // Capture FSM with the write port and status pulses registered alongside it.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            state_q      <= IDLE;
            wptr_q       <= '0;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_colr_q    <= '0;
            locked_q     <= 1'b0;
            frame_done_q <= 1'b0;
            err_short_q  <= 1'b0;
        end else begin
            fb_we_q      <= 1'b0;
            frame_done_q <= 1'b0;
            err_short_q  <= 1'b0;
            if (!enable) begin
                state_q  <= IDLE;
                locked_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: state_q <= SEEK;
                    SEEK: begin
                        if (vsync_edge_s) begin
                            state_q <= CAPTURE;
                            wptr_q  <= '0;
                        end
                    end
                    CAPTURE: begin
                        if (sample_s) begin
                            fb_we_q   <= 1'b1;
                            fb_addr_q <= wptr_q;
                            fb_colr_q <= colr_s;
                            wptr_q    <= wptr_q + ADDRW'(1);
                        end
                        // A vsync edge alongside the final write still counts as a complete frame.
                        if (sample_s && (wptr_q == LAST)) begin
                            if (vsync_edge_s) begin
                                frame_done_q <= 1'b1;
                                locked_q     <= 1'b1;
                                wptr_q       <= '0;
                            end else begin
                                state_q <= HOLD;
                            end
                        end else if (vsync_edge_s) begin
                            err_short_q <= 1'b1;
                            locked_q    <= 1'b0;
                            wptr_q      <= '0;
                        end
                    end
                    HOLD: begin
                        if (vsync_edge_s) begin
                            state_q      <= CAPTURE;
                            frame_done_q <= 1'b1;
                            locked_q     <= 1'b1;
                            wptr_q       <= '0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign fb_we      = fb_we_q;
    assign fb_addr    = fb_addr_q;
    assign fb_colr    = fb_colr_q;
    assign capturing  = (state_q == CAPTURE);
    assign locked     = locked_q;
    assign frame_done = frame_done_q;
    assign err_short  = err_short_q;

`ifdef VIDEO_CAPTURE_STATS_EN
    logic [CORDW-1:0] meas_w_q, meas_h_q;

    // Width is the pixel count of the line just ended; height is the line count of the frame just ended.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            meas_w_q <= '0;
            meas_h_q <= '0;
        end else begin
            if (de_fall_s) begin
                meas_w_q <= ax_q;
            end
            if (vsync_edge_s) begin
                meas_h_q <= ay_q;
            end
        end
    end

    assign meas_w = meas_w_q;
    assign meas_h = meas_h_q;
`else
    assign meas_w = '0;
    assign meas_h = '0;
`endif

endmodule

// File: tb/tb_video_capture.sv
// Directed bench for video_capture using a reduced window: 10x9 active source,
// 4x3 framebuffer, scale 2, offsets (1,2), active-low sync.
module tb_video_capture;

    logic        clk_pix = 1'b0;
    logic        rst_pix_n;
    logic        enable;
    logic        vid_hsync, vid_vsync, vid_de;
    logic [3:0]  vid_r, vid_g, vid_b;
    logic        fb_we;
    logic [3:0]  fb_addr;
    logic [11:0] fb_colr;
    logic        capturing, locked, frame_done, err_short;
    logic [15:0] meas_w, meas_h;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int fd_cnt = 0, fd_cyc = 0, es_cnt = 0, es_cyc = 0;
    int px_cyc = 0, vs_cyc = 0, mark = 0;
    int exp_w = 0, exp_h = 0;
    logic [3:0]  addr_log [0:255];
    logic [11:0] colr_log [0:255];
    int          cyc_log  [0:255];

    video_capture #(
        .CHANW(4), .CORDW(16), .FB_WIDTH(4), .FB_HEIGHT(3), .FB_SCALE(2),
        .CAP_OFFX(1), .CAP_OFFY(2), .SYNC_POL(0)
    ) dut (
        .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .enable(enable),
        .vid_hsync(vid_hsync), .vid_vsync(vid_vsync), .vid_de(vid_de),
        .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_colr(fb_colr),
        .capturing(capturing), .locked(locked), .frame_done(frame_done),
        .err_short(err_short), .meas_w(meas_w), .meas_h(meas_h)
    );

    always #5 clk_pix = ~clk_pix;

    always @(posedge clk_pix) cyc <= cyc + 1;

    always @(negedge clk_pix) begin
        if (fb_we) begin
            if (wr_cnt < 256) begin
                addr_log[wr_cnt] = fb_addr;
                colr_log[wr_cnt] = fb_colr;
                cyc_log[wr_cnt]  = cyc;
            end
            wr_cnt = wr_cnt + 1;
        end
        if (frame_done) begin
            fd_cnt = fd_cnt + 1;
            fd_cyc = cyc;
        end
        if (err_short) begin
            es_cnt = es_cnt + 1;
            es_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests = tests + 1;
        assert (obs === exp) else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    // Colour pattern: r = x, g = y, b = x ^ y.
    task automatic drive(input logic vs, input logic hs, input logic de, input int x, input int y);
        tick();
        vid_vsync = vs;
        vid_hsync = hs;
        vid_de    = de;
        vid_r     = de ? x[3:0] : 4'h0;
        vid_g     = de ? y[3:0] : 4'h0;
        vid_b     = de ? (x[3:0] ^ y[3:0]) : 4'h0;
    endtask

    task automatic vs_pulse();
        drive(1'b0, 1'b1, 1'b0, 0, 0);
        vs_cyc = cyc;
        drive(1'b0, 1'b1, 1'b0, 0, 0);
        drive(1'b0, 1'b1, 1'b0, 0, 0);
        drive(1'b1, 1'b1, 1'b0, 0, 0);
        drive(1'b1, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic line(input int y);
        for (int x = 0; x < 10; x++) begin
            drive(1'b1, 1'b1, 1'b1, x, y);
            if (x == 1 && y == 2) px_cyc = cyc;
        end
        drive(1'b1, 1'b0, 1'b0, 0, 0);
        drive(1'b1, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic lines(input int y0, input int y1);
        for (int y = y0; y <= y1; y++) line(y);
    endtask

    initial begin
`ifdef VIDEO_CAPTURE_STATS_EN
        exp_w = 10;
        exp_h = 9;
`endif
        rst_pix_n = 1'b0; enable = 1'b0;
        vid_vsync = 1'b1; vid_hsync = 1'b1; vid_de = 1'b0;
        vid_r = 4'h0; vid_g = 4'h0; vid_b = 4'h0;
        repeat (3) tick();
        chk("rst_we", fb_we, 0);
        chk("rst_addr", fb_addr, 0);
        chk("rst_colr", fb_colr, 0);
        chk("rst_capturing", capturing, 0);
        chk("rst_locked", locked, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_err_short", err_short, 0);
        chk("rst_meas_w", meas_w, 0);
        chk("rst_meas_h", meas_h, 0);

        // Enable without vsync: seeking, no writes.
        rst_pix_n = 1'b1; enable = 1'b1;
        tick(); tick();
        chk("seek_not_capturing", capturing, 0);
        line(0);
        chk("seek_no_writes", wr_cnt, 0);

        // First full frame.
        vs_pulse();
        chk("cap_after_vsync", capturing, 1);
        lines(0, 8);
        chk("f1_writes", wr_cnt, 12);
        chk("f1_addr0", addr_log[0], 4'd0);
        chk("f1_colr0", colr_log[0], 12'h123);
        chk("f1_addr5", addr_log[5], 4'd5);
        chk("f1_colr5", colr_log[5], 12'h347);
        chk("f1_addr11", addr_log[11], 4'd11);
        chk("f1_colr11", colr_log[11], 12'h761);
        chk("f1_latency", cyc_log[0] - px_cyc, 2);
        chk("hold_not_capturing", capturing, 0);
        chk("f1_not_locked", locked, 0);
        chk("f1_no_frame_done", fd_cnt, 0);
        chk("meas_w", meas_w, exp_w);

        // Vsync in HOLD closes the frame.
        vs_pulse();
        chk("fd_count", fd_cnt, 1);
        chk("fd_latency", fd_cyc - vs_cyc, 2);
        chk("fd_no_err", es_cnt, 0);
        chk("locked_after_fd", locked, 1);
        chk("capturing_after_fd", capturing, 1);
        chk("meas_h", meas_h, exp_h);

        // Short frame: vsync arrives after line 4.
        mark = wr_cnt;
        lines(0, 4);
        chk("f2_writes", wr_cnt - mark, 8);
        chk("f2_first_addr", addr_log[mark], 4'd0);
        vs_pulse();
        chk("err_count", es_cnt, 1);
        chk("err_latency", es_cyc - vs_cyc, 2);
        chk("err_unlocked", locked, 0);
        chk("err_still_capturing", capturing, 1);
        chk("err_no_frame_done", fd_cnt, 1);
        mark = wr_cnt;
        lines(0, 3);
        chk("err_next_writes", wr_cnt - mark, 4);
        chk("err_next_addr", addr_log[mark], 4'd0);

        // Enable dropped mid-line 4, together with pixel 5.
        mark = wr_cnt;
        for (int x = 0; x < 5; x++) drive(1'b1, 1'b1, 1'b1, x, 4);
        drive(1'b1, 1'b1, 1'b1, 5, 4);
        enable = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 6, 4);
        chk("dis_we_low", fb_we, 0);
        chk("dis_idle", capturing, 0);
        chk("dis_unlocked", locked, 0);
        for (int x = 7; x < 10; x++) drive(1'b1, 1'b1, 1'b1, x, 4);
        drive(1'b1, 1'b0, 1'b0, 0, 0);
        drive(1'b1, 1'b1, 1'b0, 0, 0);
        chk("dis_writes", wr_cnt - mark, 2);
        chk("dis_last_addr", addr_log[mark + 1], 4'd5);

        // Re-enable: nothing until the next vsync edge, then restart at 0.
        enable = 1'b1;
        mark = wr_cnt;
        lines(5, 8);
        chk("reen_no_writes", wr_cnt - mark, 0);
        chk("reen_seeking", capturing, 0);
        vs_pulse();
        lines(0, 2);
        chk("reen_writes", wr_cnt - mark, 4);
        chk("reen_addr0", addr_log[mark], 4'd0);
        chk("reen_colr0", colr_log[mark], 12'h123);

        // Asynchronous reset mid-line while writes are active.
        line(3);
        for (int x = 0; x < 8; x++) drive(1'b1, 1'b1, 1'b1, x, 4);
        chk("pre_rst_addr", fb_addr, 4'd6);
        #2 rst_pix_n = 1'b0;
        #1;
        chk("arst_we", fb_we, 0);
        chk("arst_addr", fb_addr, 0);
        chk("arst_colr", fb_colr, 0);
        chk("arst_capturing", capturing, 0);
        chk("arst_meas_w", meas_w, 0);
        tick();
        rst_pix_n = 1'b1;
        mark = wr_cnt;
        lines(0, 2);
        chk("post_rst_no_writes", wr_cnt - mark, 0);
        vs_pulse();
        lines(0, 2);
        chk("post_rst_writes", wr_cnt - mark, 4);
        chk("post_rst_addr0", addr_log[mark], 4'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
